// File: rtl/mbist_engine.sv
// March-style memory BIST engine: drives a synchronous single-port RAM through
// MATS+, March C- or checkerboard sequences and compares the read-back data.
module mbist_engine #(
  parameter int ADDR_WIDTH    = 10,
  parameter int DATA_WIDTH    = 32,
  parameter int RD_LATENCY    = 1,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     bist_start,
  input  logic                     bist_abort,
  input  logic [1:0]               algo_sel,
  output logic                     bist_busy,
  output logic                     bist_done,
  output logic                     bist_pass,
  output logic [ERR_CNT_WIDTH-1:0] error_count,
  output logic [ADDR_WIDTH-1:0]    fail_addr,
  output logic [DATA_WIDTH-1:0]    fail_syndrome,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [ADDR_WIDTH-1:0]    mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic [DATA_WIDTH-1:0]    mem_rdata
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  // op code = {write, data code}; data code 0/1 = all-zeros/ones, 2/3 = P/~P
  typedef struct packed {
    logic       two;
    logic [2:0] op0;
    logic [2:0] op1;
  } elem_t;

  localparam logic [2:0] R0 = 3'b000, R1 = 3'b001, RP = 3'b010, RN = 3'b011;
  localparam logic [2:0] W0 = 3'b100, W1 = 3'b101, WP = 3'b110, WN = 3'b111;
  localparam logic [2:0] DRAIN_LAST = 3'(RD_LATENCY - 1);

  function automatic elem_t elem_dec(input logic [1:0] algo, input logic [2:0] idx);
    elem_t e;
    case (algo)
      2'd0: case (idx)
        3'd0:    e = {1'b0, W0, W0};
        3'd1:    e = {1'b1, R0, W1};
        default: e = {1'b1, R1, W0};
      endcase
      2'd2: case (idx)
        3'd0:    e = {1'b0, WP, WP};
        3'd1:    e = {1'b0, RP, RP};
        3'd2:    e = {1'b0, WN, WN};
        default: e = {1'b0, RN, RN};
      endcase
      default: case (idx)
        3'd0:    e = {1'b0, W0, W0};
        3'd1:    e = {1'b1, R0, W1};
        3'd2:    e = {1'b1, R1, W0};
        3'd3:    e = {1'b1, R0, W1};
        3'd4:    e = {1'b1, R1, W0};
        default: e = {1'b0, R0, R0};
      endcase
    endcase
    return e;
  endfunction

  function automatic logic elem_down(input logic [1:0] algo, input logic [2:0] idx);
    case (algo)
      2'd0:    return idx == 3'd2;
      2'd2:    return 1'b0;
      default: return idx >= 3'd3;
    endcase
  endfunction

  function automatic logic [2:0] last_elem(input logic [1:0] algo);
    case (algo)
      2'd0:    return 3'd2;
      2'd2:    return 3'd3;
      default: return 3'd5;
    endcase
  endfunction

  state_t                  state_reg;
  logic [1:0]              algo_reg;
  logic [2:0]              elem_reg;
  logic                    opi_reg;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic                    last_reg;
  logic [2:0]              drain_cnt_reg;

  logic                    pipe_vld_reg  [RD_LATENCY];
  logic [ADDR_WIDTH-1:0]   pipe_addr_reg [RD_LATENCY];
  logic [DATA_WIDTH-1:0]   pipe_exp_reg  [RD_LATENCY];

  logic                    accept, abort_hit, issue, mismatch;
  logic [1:0]              algo_cur;
  logic [2:0]              elem_cur, elem_next;
  logic                    opi_cur, opi_next;
  logic [ADDR_WIDTH-1:0]   addr_cur, addr_next;
  elem_t                   e_cur;
  logic [2:0]              op_cur;
  logic                    addr_last, op_last, is_final;
  logic [DATA_WIDTH-1:0]   wdata_cur, pat_even;

  // pat_even is the 0x55 pattern used at even addresses
  for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_pat
    assign pat_even[gi] = ((gi % 2) == 0);
  end

  always_comb begin
    accept    = bist_start && (state_reg == IDLE || state_reg == DONE);
    abort_hit = bist_abort && (state_reg == RUN || state_reg == DRAIN);
    issue     = accept || (state_reg == RUN && !last_reg && !abort_hit);
    // An accepted start issues the first op at the same edge, before the regs are loaded
    algo_cur  = accept ? algo_sel : algo_reg;
    elem_cur  = accept ? 3'd0 : elem_reg;
    opi_cur   = accept ? 1'b0 : opi_reg;
    addr_cur  = accept ? '0 : addr_reg;
    e_cur     = elem_dec(algo_cur, elem_cur);
    op_cur    = opi_cur ? e_cur.op1 : e_cur.op0;
    addr_last = elem_down(algo_cur, elem_cur) ? (addr_cur == '0) : (addr_cur == '1);
    op_last   = (opi_cur == e_cur.two);
    is_final  = op_last && addr_last && (elem_cur == last_elem(algo_cur));
    elem_next = elem_cur;
    opi_next  = 1'b1;
    addr_next = addr_cur;
    if (op_last) begin
      opi_next = 1'b0;
      if (addr_last) begin
        elem_next = elem_cur + 3'd1;
        addr_next = elem_down(algo_cur, elem_next) ? '1 : '0;
      end else begin
        addr_next = elem_down(algo_cur, elem_cur) ? addr_cur - ADDR_WIDTH'(1)
                                                  : addr_cur + ADDR_WIDTH'(1);
      end
    end
    case (op_cur[1:0])
      2'd0:    wdata_cur = '0;
      2'd1:    wdata_cur = '1;
      2'd2:    wdata_cur = addr_cur[0] ? ~pat_even : pat_even;
      default: wdata_cur = addr_cur[0] ? pat_even : ~pat_even;
    endcase
    mismatch = pipe_vld_reg[RD_LATENCY-1]
            && (mem_rdata != pipe_exp_reg[RD_LATENCY-1])
            && (state_reg == RUN || state_reg == DRAIN);
  end

  // Read ops carry their address and expected data (driven on mem_wdata) down the pipe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipe_vld_reg[i]  <= 1'b0;
        pipe_addr_reg[i] <= '0;
        pipe_exp_reg[i]  <= '0;
      end
    end else begin
      pipe_vld_reg[0]  <= mem_en && !mem_we && !abort_hit;
      pipe_addr_reg[0] <= mem_addr;
      pipe_exp_reg[0]  <= mem_wdata;
      for (int i = RD_LATENCY - 1; i > 0; i--) begin
        pipe_vld_reg[i]  <= pipe_vld_reg[i-1] && !abort_hit;
        pipe_addr_reg[i] <= pipe_addr_reg[i-1];
        pipe_exp_reg[i]  <= pipe_exp_reg[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      algo_reg      <= 2'd0;
      elem_reg      <= 3'd0;
      opi_reg       <= 1'b0;
      addr_reg      <= '0;
      last_reg      <= 1'b0;
      drain_cnt_reg <= 3'd0;
      bist_busy     <= 1'b0;
      bist_done     <= 1'b0;
      bist_pass     <= 1'b0;
      error_count   <= '0;
      fail_addr     <= '0;
      fail_syndrome <= '0;
      mem_en        <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
    end else begin
      mem_en <= issue;
      mem_we <= issue && op_cur[2];
      if (issue) begin
        mem_addr  <= addr_cur;
        mem_wdata <= wdata_cur;
        elem_reg  <= elem_next;
        opi_reg   <= opi_next;
        addr_reg  <= addr_next;
        last_reg  <= is_final;
      end
      if (mismatch && !abort_hit) begin
        if (error_count != {ERR_CNT_WIDTH{1'b1}})
          error_count <= error_count + ERR_CNT_WIDTH'(1);
        if (error_count == '0) begin
          fail_addr     <= pipe_addr_reg[RD_LATENCY-1];
          fail_syndrome <= mem_rdata ^ pipe_exp_reg[RD_LATENCY-1];
        end
      end
      case (state_reg)
        IDLE, DONE: if (accept) begin
          state_reg     <= RUN;
          algo_reg      <= algo_sel;
          bist_busy     <= 1'b1;
          bist_done     <= 1'b0;
          bist_pass     <= 1'b0;
          error_count   <= '0;
          fail_addr     <= '0;
          fail_syndrome <= '0;
        end
        RUN: if (abort_hit) begin
          state_reg <= DONE;
          bist_busy <= 1'b0;
          bist_done <= 1'b1;
          bist_pass <= 1'b0;
        end else if (last_reg) begin
          state_reg     <= DRAIN;
          drain_cnt_reg <= 3'd0;
        end
        DRAIN: if (abort_hit) begin
          state_reg <= DONE;
          bist_busy <= 1'b0;
          bist_done <= 1'b1;
          bist_pass <= 1'b0;
        end else if (drain_cnt_reg == DRAIN_LAST) begin
          // The final compare lands on this edge, so fold it into the verdict
          state_reg <= DONE;
          bist_busy <= 1'b0;
          bist_done <= 1'b1;
          bist_pass <= (error_count == '0) && !mismatch;
        end else begin
          drain_cnt_reg <= drain_cnt_reg + 3'd1;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mbist_engine.sv
// Bench for mbist_engine: two instances (latency 1 / 16-bit counter, latency 3 / 4-bit
// counter) on behavioural RAMs with injectable faults, checked against a march-list model.
module tb_mbist_engine;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int W0 = 0, W1 = 1, WP = 2, WN = 3, R0 = 10, R1 = 11, RP = 12, RN = 13;

  typedef struct {
    int            addr;
    bit            we;
    logic [DW-1:0] d;
  } op_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic          start [2];
  logic          abort [2];
  logic [1:0]    algo  [2];
  logic          busy  [2];
  logic          done  [2];
  logic          pass  [2];
  logic [15:0]   errc0;
  logic [3:0]    errc1;
  logic [AW-1:0] fa    [2];
  logic [DW-1:0] fs    [2];
  logic          men   [2];
  logic          mwe   [2];
  logic [AW-1:0] maddr [2];
  logic [DW-1:0] mwd   [2];
  logic [DW-1:0] mrd   [2];

  mbist_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1), .ERR_CNT_WIDTH(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .bist_start(start[0]), .bist_abort(abort[0]), .algo_sel(algo[0]),
    .bist_busy(busy[0]), .bist_done(done[0]), .bist_pass(pass[0]), .error_count(errc0),
    .fail_addr(fa[0]), .fail_syndrome(fs[0]), .mem_en(men[0]), .mem_we(mwe[0]),
    .mem_addr(maddr[0]), .mem_wdata(mwd[0]), .mem_rdata(mrd[0]));

  mbist_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(3), .ERR_CNT_WIDTH(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .bist_start(start[1]), .bist_abort(abort[1]), .algo_sel(algo[1]),
    .bist_busy(busy[1]), .bist_done(done[1]), .bist_pass(pass[1]), .error_count(errc1),
    .fail_addr(fa[1]), .fail_syndrome(fs[1]), .mem_en(men[1]), .mem_we(mwe[1]),
    .mem_addr(maddr[1]), .mem_wdata(mwd[1]), .mem_rdata(mrd[1]));

  // Behavioural RAMs: fault mode 1 = one bit stuck at 1 at one address, 2 = every read inverted
  logic [DW-1:0] mem [2][16];
  logic [DW-1:0] dly [2][3];
  int fmode [2];
  int faddr [2];
  int fbit  [2];

  function automatic logic [DW-1:0] faulty(input int i, input logic [DW-1:0] v, input int a);
    logic [DW-1:0] r;
    r = v;
    if (fmode[i] == 1 && a == faddr[i]) r[fbit[i]] = 1'b1;
    if (fmode[i] == 2) r = ~r;
    return r;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (men[i] && mwe[i]) mem[i][maddr[i]] <= mwd[i];
      dly[i][0] <= faulty(i, mem[i][maddr[i]], int'(maddr[i]));
      dly[i][1] <= dly[i][0];
      dly[i][2] <= dly[i][1];
    end
  end
  assign mrd[0] = dly[0][0];
  assign mrd[1] = dly[1][2];

  int  tests_run = 0;
  int  tests_failed = 0;
  op_t ops[$];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests_run++;
    assert (got === exp) else begin
      tests_failed++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] pval(input int code, input int a);
    logic [DW-1:0] p;
    p = (a % 2 == 1) ? 32'hAAAA_AAAA : 32'h5555_5555;
    case (code)
      0:       return '0;
      1:       return '1;
      2:       return p;
      default: return ~p;
    endcase
  endfunction

  function automatic void push_op(input int a, input int code);
    op_t o;
    o.addr = a;
    o.we   = (code < 10);
    o.d    = pval(code % 10, a);
    ops.push_back(o);
  endfunction

  function automatic void add_elem(input bit down, input int c0, input int c1);
    for (int i = 0; i < 16; i++) begin
      int a = down ? 15 - i : i;
      push_op(a, c0);
      if (c1 >= 0) push_op(a, c1);
    end
  endfunction

  function automatic void build(input int alg);
    ops.delete();
    case (alg)
      0: begin
        add_elem(0, W0, -1); add_elem(0, R0, W1); add_elem(1, R1, W0);
      end
      2: begin
        add_elem(0, WP, -1); add_elem(0, RP, -1); add_elem(0, WN, -1); add_elem(0, RN, -1);
      end
      default: begin
        add_elem(0, W0, -1); add_elem(0, R0, W1); add_elem(0, R1, W0);
        add_elem(1, R0, W1); add_elem(1, R1, W0); add_elem(1, R0, -1);
      end
    endcase
  endfunction

  task automatic run_test(input string tag, input int sel, input int alg, input int fm,
                          input int fad, input int fbt, input int abort_at,
                          input int mid_start, input bit late_start);
    int n, lat, maxc, exp_err, exp_fa, last_op, bound, done_cyc, op_err, done_drop;
    logic [DW-1:0] exp_fs, rd;
    logic [DW-1:0] m [16];
    logic [15:0] ec;
    bit exp_en;
    op_t o;
    lat = sel ? 3 : 1;
    maxc = sel ? 15 : 65535;
    fmode[sel] = fm; faddr[sel] = fad; fbit[sel] = fbt;
    build(alg);
    n = ops.size();
    for (int a = 0; a < 16; a++) m[a] = '0;
    exp_err = 0; exp_fa = 0; exp_fs = '0;
    foreach (ops[k]) begin
      if (ops[k].we) m[ops[k].addr] = ops[k].d;
      else begin
        rd = m[ops[k].addr];
        if (fm == 1 && ops[k].addr == fad) rd[fbt] = 1'b1;
        if (fm == 2) rd = ~rd;
        if (rd !== ops[k].d) begin
          if (exp_err == 0) begin exp_fa = ops[k].addr; exp_fs = rd ^ ops[k].d; end
          if (exp_err < maxc) exp_err++;
        end
      end
    end
    last_op = (abort_at > 0 && abort_at < n) ? abort_at : n;
    bound = (abort_at > 0) ? abort_at + 3 : n + lat + 3;
    done_cyc = 0; op_err = 0; done_drop = 0;

    @(negedge clk);
    algo[sel] = 2'(alg);
    start[sel] = 1'b1;
    for (int c = 1; c <= bound; c++) begin
      @(negedge clk);
      if (c == 1) start[sel] = 1'b0;
      exp_en = (c <= last_op);
      if (men[sel] !== exp_en) op_err++;
      else if (exp_en) begin
        o = ops[c-1];
        if (maddr[sel] !== o.addr[AW-1:0] || mwe[sel] !== o.we || (o.we && mwd[sel] !== o.d))
          op_err++;
      end
      if (done[sel] && done_cyc == 0) done_cyc = c;
      if (!done[sel] && done_cyc != 0) done_drop++;
      if (mid_start > 0 && c == mid_start) begin
        start[sel] = 1'b1; algo[sel] = 2'(alg) ^ 2'b11;
      end else if (mid_start > 0 && c == mid_start + 1) begin
        start[sel] = 1'b0; algo[sel] = 2'(alg);
      end
      if (late_start && c == n + lat) start[sel] = 1'b1;
      else if (late_start && c == n + lat + 1) start[sel] = 1'b0;
      if (abort_at > 0 && c == abort_at) abort[sel] = 1'b1;
      else if (abort_at > 0 && c == abort_at + 1) abort[sel] = 1'b0;
    end

    ec = sel ? {12'd0, errc1} : errc0;
    if (abort_at > 0) begin exp_err = 0; exp_fa = 0; exp_fs = '0; end
    check({tag, ".op_stream"}, 128'(op_err), 128'd0);
    check({tag, ".done_cycle"}, 128'(done_cyc), 128'((abort_at > 0) ? abort_at + 1 : n + lat + 1));
    check({tag, ".done_held"}, 128'(done_drop), 128'd0);
    check({tag, ".busy"}, 128'(busy[sel]), 128'd0);
    check({tag, ".pass"}, 128'(pass[sel]), 128'((abort_at == 0 && exp_err == 0) ? 1 : 0));
    check({tag, ".error_count"}, 128'(ec), 128'(exp_err));
    check({tag, ".fail_addr"}, 128'(fa[sel]), 128'(exp_fa));
    check({tag, ".fail_syndrome"}, 128'(fs[sel]), 128'(exp_fs));
    $display("[TB] %s: inst=%0d algo=%0d ops=%0d done_cycle=%0d error_count=%0d pass=%0d",
             tag, sel, alg, n, done_cyc, ec, pass[sel]);
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      start[s] = 1'b0; abort[s] = 1'b0; algo[s] = 2'd0;
      fmode[s] = 0; faddr[s] = 0; fbit[s] = 0;
      for (int a = 0; a < 16; a++) mem[s][a] = $urandom;
    end
    #2 rst_n = 1'b0;
    #1;
    for (int s = 0; s < 2; s++) begin
      check($sformatf("reset%0d.busy_done_pass", s), {busy[s], done[s], pass[s]}, '0);
      check($sformatf("reset%0d.mem_ctrl", s), {men[s], mwe[s], maddr[s], mwd[s]}, '0);
      check($sformatf("reset%0d.fail_info", s), {fa[s], fs[s]}, '0);
    end
    check("reset.error_count", {errc0, errc1}, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_test("march_ok",   0, 1, 0, 0, 0, 0, 0, 0);
    run_test("march_stuck", 0, 1, 1, 5, 3, 0, 0, 0);
    run_test("mats_l3",    1, 0, 0, 0, 0, 0, 0, 0);
    run_test("ckb_l3",     1, 2, 0, 0, 0, 0, 0, 0);
    run_test("abort",      0, 1, 0, 0, 0, 20, 10, 0);
    run_test("saturate",   1, 1, 2, 0, 0, 0, 0, 0);
    run_test("late_start", 1, 3, 0, 0, 0, 0, 0, 1);

    // Reset mid-test with a fault already logged
    fmode[0] = 1; faddr[0] = 5; fbit[0] = 3;
    @(negedge clk);
    algo[0] = 2'd1; start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (29) @(negedge clk);
    check("midrun.error_count", 128'(errc0), 128'd1);
    check("midrun.mem_en", 128'(men[0]), 128'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst.status", {busy[0], done[0], pass[0], errc0}, '0);
    check("async_rst.mem", {men[0], mwe[0], maddr[0], mwd[0]}, '0);
    check("async_rst.fail_info", {fa[0], fs[0]}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst.idle", {men[0], busy[0], done[0]}, '0);
    run_test("post_rst", 0, 1, 0, 0, 0, 0, 0, 0);

    for (int r = 0; r < 6; r++) begin
      int sel, alg, fm;
      sel = int'($urandom_range(0, 1));
      alg = int'($urandom_range(0, 3));
      fm  = int'($urandom_range(0, 2));
      run_test($sformatf("rand%0d", r), sel, alg, fm,
               int'($urandom_range(0, 15)), int'($urandom_range(0, DW - 1)), 0, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
